seq_detector_prog: RTL and testbench

Programmable serial pattern detector, the parametrised successor to the fixed 1011 detector. It takes one serial bit per qualified cycle and pulses z when the last pat_len bits equal a runtime-loaded pattern. It supports overlapping and non-overlapping match modes and keeps a saturating match counter. It sits on serial-stream monitors and feeds status/interrupt logic.

---
 rtl/seq_det_pkg.sv | 8 +
 rtl/seq_shift_hist.sv | 37 +++
 rtl/seq_detector_prog.sv | 87 ++++++++
 tb/tb_seq_detector_prog.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types, default pattern and length-width helper for the serial pattern detector
package seq_det_pkg;
    typedef enum logic {MODE_NONOVL = 1'b0, MODE_OVL = 1'b1} mode_e;
    localparam logic [3:0] DEF_PAT = 4'b1011;
    function automatic int len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction
endpackage

// File: rtl/seq_shift_hist.sv
// seq_shift_hist: serial history shift register with saturating fill count, flush and match drop
module seq_shift_hist
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 4,
    localparam int LEN_W = len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             sample,
    input  logic             drop,
    input  logic             x,
    input  logic [LEN_W-1:0] cur_len,
    output logic [PAT_W-1:0] hist_nxt,
    output logic [LEN_W-1:0] fill,
    output logic [LEN_W-1:0] fill_nxt
);
    // the oldest bit falls off on the next shift, so only PAT_W-1 bits are stored
    logic [PAT_W-2:0] hist;
    always_comb begin
        hist_nxt = {hist, x};
        fill_nxt = (fill >= cur_len) ? cur_len : fill + 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
            fill <= '0;
        end else if (flush) begin
            hist <= '0;
            fill <= '0;
        end else if (sample) begin
            hist <= hist_nxt[PAT_W-2:0];
            fill <= drop ? '0 : fill_nxt;
        end
    end
endmodule

// File: rtl/seq_detector_prog.sv
// seq_detector_prog: programmable serial pattern detector with saturating match counter
// SEQ_DET_STICKY_EN adds a sticky hit output set by any match and cleared by cnt_clr
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_PAT),
    localparam int LEN_W = len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             x,
    input  logic             ovl,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [LEN_W-1:0] len_in,
    input  logic             cnt_clr,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic [LEN_W-1:0] fill
`ifdef SEQ_DET_STICKY_EN
    ,
    output logic             hit
`endif
);
    logic [PAT_W-1:0] cur_pat, hist_nxt, mask;
    logic [LEN_W-1:0] cur_len, len_cl, fill_nxt;
    logic             sample, match, drop;

    seq_shift_hist #(.PAT_W(PAT_W)) u_hist (
        .clk(clk),
        .rst_n(rst_n),
        .flush(cfg_load),
        .sample(sample),
        .drop(drop),
        .x(x),
        .cur_len(cur_len),
        .hist_nxt(hist_nxt),
        .fill(fill),
        .fill_nxt(fill_nxt)
    );

    // a shift by PAT_W empties the ones, so the full-length mask is all ones
    always_comb begin
        sample = en & ~cfg_load;
        len_cl = (len_in == '0 || len_in > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len_in;
        mask = ~({PAT_W{1'b1}} << cur_len);
        match = sample && fill_nxt == cur_len && ((hist_nxt ^ cur_pat) & mask) == '0;
        drop = match && mode_e'(ovl) == MODE_NONOVL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_pat <= RST_PAT;
            cur_len <= LEN_W'(PAT_W);
        end else if (cfg_load) begin
            cur_pat <= pat_in;
            cur_len <= len_cl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z         <= 1'b0;
            match_cnt <= '0;
        end else begin
            z <= match;
            if (cnt_clr)
                match_cnt <= '0;
            else if (match && match_cnt != '1)
                match_cnt <= match_cnt + 1'b1;
        end
    end

`ifdef SEQ_DET_STICKY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hit <= 1'b0;
        else if (cnt_clr)
            hit <= 1'b0;
        else if (match)
            hit <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_seq_detector_prog.sv
// tb_seq_detector_prog: directed self-checking bench for seq_detector_prog (PAT_W=4, CNT_W=2)
// SEQ_DET_STICKY_EN enables the sticky hit checks
module tb_seq_detector_prog;
    logic       clk = 0, rst_n = 0, en = 0, x = 0, ovl = 1, cfg_load = 0, cnt_clr = 0;
    logic [3:0] pat_in = 0;
    logic [2:0] len_in = 0;
    logic       z;
    logic [1:0] match_cnt;
    logic [2:0] fill;
`ifdef SEQ_DET_STICKY_EN
    logic       hit;
`endif
    int tests = 0, fails = 0;

    seq_detector_prog #(.PAT_W(4), .CNT_W(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .x(x),
        .ovl(ovl),
        .cfg_load(cfg_load),
        .pat_in(pat_in),
        .len_in(len_in),
        .cnt_clr(cnt_clr),
        .z(z),
        .match_cnt(match_cnt),
        .fill(fill)
`ifdef SEQ_DET_STICKY_EN
        ,
        .hit(hit)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_in(input logic b);
        en = 1;
        x = b;
        tick();
        en = 0;
    endtask

    // x=1 with en=1 during the load must be discarded
    task automatic cfg(input logic [3:0] p, input logic [2:0] l);
        cfg_load = 1;
        pat_in = p;
        len_in = l;
        cnt_clr = 1;
        en = 1;
        x = 1;
        tick();
        cfg_load = 0;
        cnt_clr = 0;
        en = 0;
    endtask

    task automatic feed(input string name, input logic [15:0] s, input int n, input logic [15:0] zexp);
        for (int i = n - 1; i >= 0; i--) begin
            bit_in(s[i]);
            tests++;
            if (z !== zexp[i]) begin
                fails++;
                $display("FAIL %s bit %0d: z=%b expected %b", name, n - i, z, zexp[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        #3;
        tests++;
        if (z !== 1'b0 || match_cnt !== 2'd0 || fill !== 3'd0) begin
            fails++;
            $display("FAIL reset: z=%b cnt=%0d fill=%0d expected 0 0 0", z, match_cnt, fill);
        end
`ifdef SEQ_DET_STICKY_EN
        tests++;
        if (hit !== 1'b0) begin
            fails++;
            $display("FAIL reset_hit: hit=%b expected 0", hit);
        end
`endif
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_overlap();
        ovl = 1;
        feed("overlap", 16'b1101011011, 10, 16'b0000001001);
        tests++;
        if (match_cnt !== 2'd2 || fill !== 3'd4) begin
            fails++;
            $display("FAIL overlap_end: cnt=%0d fill=%0d expected 2 4", match_cnt, fill);
        end
    endtask

    task automatic test_nonoverlap();
        cfg(4'b1011, 3'd4);
        tests++;
        if (z !== 1'b0 || match_cnt !== 2'd0 || fill !== 3'd0) begin
            fails++;
            $display("FAIL cfg_flush: z=%b cnt=%0d fill=%0d expected 0 0 0", z, match_cnt, fill);
        end
        ovl = 0;
        feed("nonoverlap", 16'b1101011011, 10, 16'b0000001000);
        tests++;
        if (match_cnt !== 2'd1 || fill !== 3'd3) begin
            fails++;
            $display("FAIL nonoverlap_end: cnt=%0d fill=%0d expected 1 3", match_cnt, fill);
        end
        ovl = 1;
    endtask

    task automatic test_len3();
        cfg(4'b0110, 3'd3);
        tests++;
        if (fill !== 3'd0) begin
            fails++;
            $display("FAIL len3_load_discard: fill=%0d expected 0", fill);
        end
        feed("len3", 16'b110110, 6, 16'b001001);
        tests++;
        if (match_cnt !== 2'd2 || fill !== 3'd3) begin
            fails++;
            $display("FAIL len3_end: cnt=%0d fill=%0d expected 2 3", match_cnt, fill);
        end
        cfg(4'b1011, 3'd0);
        feed("len0_clamp", 16'b11111, 5, 16'b00000);
        tests++;
        if (fill !== 3'd4) begin
            fails++;
            $display("FAIL len0_fill: fill=%0d expected 4", fill);
        end
        cfg(4'b1011, 3'd7);
        feed("len7_clamp", 16'b1011, 4, 16'b0001);
        tests++;
        if (fill !== 3'd4 || match_cnt !== 2'd1) begin
            fails++;
            $display("FAIL len7_end: fill=%0d cnt=%0d expected 4 1", fill, match_cnt);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_cnt [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
        cfg(4'b0001, 3'd1);
        for (int i = 0; i < 4; i++) begin
            bit_in(1'b1);
            tests++;
            if (z !== 1'b1 || match_cnt !== exp_cnt[i]) begin
                fails++;
                $display("FAIL saturate_%0d: z=%b cnt=%0d expected 1 %0d", i + 1, z, match_cnt, exp_cnt[i]);
            end
        end
        cnt_clr = 1;
        bit_in(1'b1);
        cnt_clr = 0;
        tests++;
        if (z !== 1'b1 || match_cnt !== 2'd0) begin
            fails++;
            $display("FAIL clr_wins: z=%b cnt=%0d expected 1 0", z, match_cnt);
        end
    endtask

    task automatic test_en_gaps();
        logic [3:0] pat = 4'b1011;
        logic [3:0] junk = 4'b1010;
        cfg(4'b1011, 3'd4);
        for (int i = 3; i >= 0; i--) begin
            bit_in(pat[i]);
            tests++;
            if (z !== (i == 0)) begin
                fails++;
                $display("FAIL en_gap_bit%0d: z=%b expected %b", 4 - i, z, i == 0);
            end
            if (i != 0) begin
                for (int g = 0; g < 2; g++) begin
                    en = 0;
                    x = junk[i];
                    tick();
                    tests++;
                    if (z !== 1'b0 || fill !== 3'(4 - i)) begin
                        fails++;
                        $display("FAIL en_gap_hold: z=%b fill=%0d expected 0 %0d", z, fill, 4 - i);
                    end
                end
            end
        end
        tick();
        tests++;
        if (z !== 1'b0 || match_cnt !== 2'd1) begin
            fails++;
            $display("FAIL en_gap_end: z=%b cnt=%0d expected 0 1", z, match_cnt);
        end
    endtask

    task automatic test_reset_mid();
        cfg(4'b0111, 3'd4);
        feed("pre_reset", 16'b101, 3, 16'b000);
        #2;
        rst_n = 0;
        #1;
        tests++;
        if (z !== 1'b0 || match_cnt !== 2'd0 || fill !== 3'd0) begin
            fails++;
            $display("FAIL mid_reset: z=%b cnt=%0d fill=%0d expected 0 0 0", z, match_cnt, fill);
        end
        tick();
        rst_n = 1;
        bit_in(1'b1);
        tests++;
        if (z !== 1'b0 || fill !== 3'd1) begin
            fails++;
            $display("FAIL post_reset: z=%b fill=%0d expected 0 1", z, fill);
        end
        feed("post_reset_default", 16'b011, 3, 16'b001);
    endtask

`ifdef SEQ_DET_STICKY_EN
    task automatic test_sticky();
        cfg(4'b0001, 3'd1);
        bit_in(1'b0);
        tests++;
        if (hit !== 1'b0) begin
            fails++;
            $display("FAIL sticky_idle: hit=%b expected 0", hit);
        end
        bit_in(1'b1);
        bit_in(1'b0);
        tests++;
        if (hit !== 1'b1 || z !== 1'b0) begin
            fails++;
            $display("FAIL sticky_hold: hit=%b z=%b expected 1 0", hit, z);
        end
        cnt_clr = 1;
        tick();
        tests++;
        if (hit !== 1'b0) begin
            fails++;
            $display("FAIL sticky_clr: hit=%b expected 0", hit);
        end
        bit_in(1'b1);
        cnt_clr = 0;
        tests++;
        if (hit !== 1'b0 || z !== 1'b1) begin
            fails++;
            $display("FAIL sticky_clr_wins: hit=%b z=%b expected 0 1", hit, z);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_len3();
        test_saturate();
        test_en_gaps();
        test_reset_mid();
`ifdef SEQ_DET_STICKY_EN
        test_sticky();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
